// File: rtl/led_strand_driver.sv
// Serial driver for a WS281x-style LED strand: fetches GRB colours from an external
// buffer, emits NRZ-coded bits and closes each frame with a latch gap.
module led_strand_driver #(
   parameter int NUM_LEDS          = 50,
   parameter int LED_ADDRESS_WIDTH = 10,
   parameter int T0H_CYCLES        = 35,
   parameter int T0L_CYCLES        = 90,
   parameter int T1H_CYCLES        = 70,
   parameter int T1L_CYCLES        = 55,
   parameter int RESET_CYCLES      = 6000
) (
   input  logic                         clk_led,
   input  logic                         rst,
   input  logic                         enable,
   output logic [LED_ADDRESS_WIDTH-1:0] next_led_request_address,
   input  logic [7:0]                   green_in,
   input  logic [7:0]                   red_in,
   input  logic [7:0]                   blue_in,
   input  logic                         color_valid,
   output logic                         strand_out,
   output logic                         busy,
   output logic                         frame_done
);

   localparam int MAX_H = (T0H_CYCLES > T1H_CYCLES) ? T0H_CYCLES : T1H_CYCLES;
   localparam int MAX_L = (T0L_CYCLES > T1L_CYCLES) ? T0L_CYCLES : T1L_CYCLES;
   localparam int MAX_B = (MAX_H > MAX_L) ? MAX_H : MAX_L;
   localparam int MAX_T = (MAX_B > RESET_CYCLES) ? MAX_B : RESET_CYCLES;
   localparam int CW    = $clog2(MAX_T + 1);
   localparam int AW    = LED_ADDRESS_WIDTH;
   localparam logic [AW-1:0] LAST_LED = AW'(NUM_LEDS - 1);

   typedef enum logic [2:0] {IDLE, FETCH, BIT_HIGH, BIT_LOW, LATCH_GAP} state_t;

   state_t          state;
   logic [23:0]     shreg;
   logic [4:0]      bit_idx;
   logic [CW-1:0]   cnt;
   logic [AW-1:0]   led_idx;
   logic [1:0]      dwell;
   logic            colour_ready;
   logic            last_bit_done;
   logic            load;
   logic [AW-1:0]   load_idx;
   logic [23:0]     grb_in;

   function automatic logic [CW-1:0] high_len(input logic b);
      return b ? CW'(T1H_CYCLES - 1) : CW'(T0H_CYCLES - 1);
   endfunction

   function automatic logic [CW-1:0] low_len(input logic b);
      return b ? CW'(T1L_CYCLES - 1) : CW'(T0L_CYCLES - 1);
   endfunction

   assign grb_in        = {green_in, red_in, blue_in};
   assign colour_ready  = (dwell == 2'd3) && color_valid;
   assign last_bit_done = (state == BIT_LOW) && (cnt == '0) && (bit_idx == 5'd0);
   // The buffer address always equals the LED about to be loaded, so one load path serves both cases.
   assign load_idx      = (state == FETCH) ? led_idx : led_idx + 1'b1;
   assign load          = colour_ready &&
                          ((state == FETCH) || (last_bit_done && (led_idx != LAST_LED)));

   always_ff @(posedge clk_led) begin
      if (rst) begin
         state                    <= IDLE;
         shreg                    <= '0;
         bit_idx                  <= '0;
         cnt                      <= '0;
         led_idx                  <= '0;
         dwell                    <= '0;
         next_led_request_address <= '0;
         strand_out               <= 1'b0;
         busy                     <= 1'b0;
         frame_done               <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (dwell != 2'd3) dwell <= dwell + 2'd1;

         case (state)
            IDLE: begin
               strand_out <= 1'b0;
               if (enable) begin
                  state   <= FETCH;
                  busy    <= 1'b1;
                  led_idx <= '0;
               end
            end
            FETCH: ;
            BIT_HIGH: begin
               if (cnt == '0) begin
                  state      <= BIT_LOW;
                  strand_out <= 1'b0;
                  cnt        <= low_len(shreg[23]);
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            BIT_LOW: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else if (bit_idx != 5'd0) begin
                  bit_idx    <= bit_idx - 5'd1;
                  shreg      <= {shreg[22:0], 1'b0};
                  cnt        <= high_len(shreg[22]);
                  strand_out <= 1'b1;
                  state      <= BIT_HIGH;
               end else if (led_idx == LAST_LED) begin
                  state                    <= LATCH_GAP;
                  cnt                      <= CW'(RESET_CYCLES - 1);
                  led_idx                  <= '0;
                  next_led_request_address <= '0;
                  if (next_led_request_address != '0) dwell <= '0;
               end
               // otherwise stall low until the next colour is ready
            end
            LATCH_GAP: begin
               if (cnt == '0) begin
                  state      <= IDLE;
                  busy       <= 1'b0;
                  frame_done <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase

         if (load) begin
            shreg      <= grb_in;
            bit_idx    <= 5'd23;
            cnt        <= high_len(green_in[7]);
            strand_out <= 1'b1;
            state      <= BIT_HIGH;
            led_idx    <= load_idx;
            if (load_idx != LAST_LED) begin
               next_led_request_address <= load_idx + 1'b1;
               dwell                    <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_led_strand_driver.sv
// Directed bench for led_strand_driver: 3-LED frames against a colour buffer model
// that only validates an address after it has been stable for 3 cycles.
module tb_led_strand_driver;

   localparam int NL    = 3;
   localparam int RST_C = 6000;
   localparam int BOUND = 10000;
   localparam logic [23:0] C0 = 24'hA0500F;
   localparam logic [23:0] C1 = 24'h3C81E7;
   localparam logic [23:0] C2 = 24'h55AA01;

   logic       clk_led = 1'b0;
   logic       rst;
   logic       enable;
   logic [9:0] addr;
   logic [7:0] green_in, red_in, blue_in;
   logic       color_valid;
   logic       strand_out, busy, frame_done;

   int         checks   = 0;
   int         failures = 0;
   int         fd_cycles = 0;
   logic       stall_en = 1'b0;
   logic [9:0] last_addr = '0;
   int         stable = 0;
   logic [23:0] grb;

   led_strand_driver #(.NUM_LEDS(NL)) dut (
      .clk_led                  (clk_led),
      .rst                      (rst),
      .enable                   (enable),
      .next_led_request_address (addr),
      .green_in                 (green_in),
      .red_in                   (red_in),
      .blue_in                  (blue_in),
      .color_valid              (color_valid),
      .strand_out               (strand_out),
      .busy                     (busy),
      .frame_done               (frame_done)
   );

   always #5 clk_led = ~clk_led;

   // colour buffer model
   assign grb = (addr == 10'd0) ? C0 : (addr == 10'd1) ? C1 : (addr == 10'd2) ? C2 : 24'h0;
   assign {green_in, red_in, blue_in} = grb;
   assign color_valid = (stable == 3) && !(stall_en && addr == 10'd1);

   always @(posedge clk_led) begin
      if (addr != last_addr) begin
         last_addr <= addr;
         stable    <= 0;
      end else if (stable < 3) begin
         stable <= stable + 1;
      end
      if (frame_done === 1'b1) fd_cycles <= fd_cycles + 1;
   end

   task automatic chk(input int obs, input int exp, input string tag);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Called at a negedge sample point; measures one high run and the following low run.
   task automatic get_pulse(output int hi, output int lo, input int rel_at, input string tag);
      int t = 0;
      hi = 0;
      lo = 0;
      while (strand_out !== 1'b1) begin
         if (t >= BOUND) begin
            chk(0, 1, {tag, " rise timeout"});
            return;
         end
         @(negedge clk_led);
         t++;
      end
      while (strand_out === 1'b1 && hi < BOUND) begin
         hi++;
         @(negedge clk_led);
      end
      while (strand_out === 1'b0 && frame_done !== 1'b1 && lo < BOUND) begin
         lo++;
         if (rel_at != 0 && lo == rel_at) stall_en = 1'b0;
         @(negedge clk_led);
      end
   endtask

   task automatic check_led(input logic [23:0] c, input string tag, input int exp_addr,
                            input bit last, input int rel_at);
      int hi, lo, exp_lo;
      for (int i = 23; i >= 0; i--) begin
         get_pulse(hi, lo, (i == 0) ? rel_at : 0, tag);
         chk(hi, c[i] ? 70 : 35, $sformatf("%s bit%0d high", tag, 23 - i));
         exp_lo = c[i] ? 55 : 90;
         if (i == 0 && rel_at != 0) exp_lo = rel_at;
         else if (i == 0 && last)   exp_lo = exp_lo + RST_C;
         chk(lo, exp_lo, $sformatf("%s bit%0d low", tag, 23 - i));
         if (i == 23) chk(int'(addr), exp_addr, {tag, " prefetch addr"});
      end
   endtask

   initial begin
      int hi, lo, hcount;
      rst    = 1'b1;
      enable = 1'b0;
      repeat (3) @(negedge clk_led);
      chk(int'(strand_out), 0, "reset strand");
      chk(int'(addr), 0, "reset addr");
      chk(int'(busy), 0, "reset busy");
      chk(int'(frame_done), 0, "reset frame_done");

      // frame A, enable held so frame B follows back-to-back
      rst    = 1'b0;
      enable = 1'b1;
      @(negedge clk_led);
      check_led(C0, "A0", 1, 1'b0, 0);
      check_led(C1, "A1", 2, 1'b0, 0);
      check_led(C2, "A2", 2, 1'b1, 0);
      chk(int'(frame_done), 1, "A frame_done");
      chk(int'(busy), 0, "A busy at done");
      chk(int'(addr), 0, "A addr wrap");

      // frame B: colour of LED 1 withheld for 600 cycles after LED 0 ends
      stall_en = 1'b1;
      check_led(C0, "B0", 1, 1'b0, 600);
      chk(fd_cycles, 1, "A frame_done cycles");
      enable = 1'b0;
      check_led(C1, "B1", 2, 1'b0, 0);
      check_led(C2, "B2", 2, 1'b1, 0);
      chk(int'(frame_done), 1, "B frame_done");
      chk(int'(busy), 0, "B busy at done");
      hcount = 0;
      repeat (300) begin
         @(negedge clk_led);
         if (strand_out !== 1'b0 || busy !== 1'b0) hcount++;
      end
      chk(hcount, 0, "no frame after B");
      chk(fd_cycles, 2, "B frame_done cycles");

      // frame C: reset during LED 2 bit 5 high
      enable = 1'b1;
      repeat (2) @(negedge clk_led);
      chk(int'(busy), 1, "C busy");
      enable = 1'b0;
      check_led(C0, "C0", 1, 1'b0, 0);
      check_led(C1, "C1", 2, 1'b0, 0);
      for (int i = 23; i >= 19; i--) begin
         get_pulse(hi, lo, 0, "C2");
         chk(hi, C2[i] ? 70 : 35, $sformatf("C2 bit%0d high", 23 - i));
      end
      chk(int'(strand_out), 1, "C2 bit5 high before rst");
      rst = 1'b1;
      @(negedge clk_led);
      chk(int'(strand_out), 0, "rst strand");
      chk(int'(addr), 0, "rst addr");
      chk(int'(busy), 0, "rst busy");
      rst = 1'b0;
      hcount = 0;
      repeat (50) begin
         @(negedge clk_led);
         if (strand_out !== 1'b0 || busy !== 1'b0) hcount++;
      end
      chk(hcount, 0, "idle after rst");
      chk(fd_cycles, 2, "no frame_done on rst");

      // frame D restarts from LED 0
      enable = 1'b1;
      @(negedge clk_led);
      enable = 1'b0;
      check_led(C0, "D0", 1, 1'b0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
